// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM read-data capture stage: FSM state
// encodings and default widths/latencies.
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int IDDR_LAT_DEF = 2;
    localparam int LAT_W_DEF    = 5;
    localparam int BL_W_DEF     = 6;

endpackage

// File: rtl/psram_rd_capture.sv
// PSRAM read-data capture: skips initial latency, packs {q0,q1} into 16-bit
// words and streams burst_len words. Define PSRAM_RD_CAPTURE_RWDS_EN to
// qualify each capture cycle on RWDS (rising=1, falling=0).
module psram_rd_capture
    import psram_pkg::*;
#(
    parameter int IDDR_LAT = IDDR_LAT_DEF,
    parameter int LAT_W    = LAT_W_DEF,
    parameter int BL_W     = BL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [LAT_W-1:0] latency,
    input  logic [BL_W-1:0]  burst_len,
    input  logic [7:0]       q0,
    input  logic [7:0]       q1,
    input  logic             rwds_q0,
    input  logic             rwds_q1,
    output logic [15:0]      rdata,
    output logic             rdata_valid,
    output logic             busy,
    output logic             done
);

    localparam int WAIT_W = LAT_W + 2;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BL_W-1:0]     remaining;
    logic [WAIT_W-1:0]   wait_init;
    logic                qualify;

    // Two spare bits keep latency + IDDR_LAT from overflowing.
    assign wait_init = {2'b00, latency} + WAIT_W'(IDDR_LAT);

`ifdef PSRAM_RD_CAPTURE_RWDS_EN
    assign qualify = rwds_q0 & ~rwds_q1;
`else
    logic unused_rwds;
    assign unused_rwds = rwds_q0 | rwds_q1;
    assign qualify     = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            remaining   <= '0;
            rdata       <= 16'h0000;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            // Abort wins over everything; a word sampled now is dropped.
            if (cancel && state != ST_IDLE) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                wait_cnt  <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            remaining <= burst_len;
                            wait_cnt  <= wait_init;
                            busy      <= 1'b1;
                            if (burst_len == '0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else if (wait_init == '0) begin
                                state <= ST_CAPTURE;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt <= WAIT_W'(1))
                            state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (qualify) begin
                            rdata       <= {q0, q1};
                            rdata_valid <= 1'b1;
                            remaining   <= remaining - BL_W'(1);
                            // done lands in the same cycle as the last strobe
                            if (remaining == BL_W'(1)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_rd_capture.sv
// Directed bench for psram_rd_capture with a word scoreboard; honours
// PSRAM_RD_CAPTURE_RWDS_EN when building expectations.
module tb_psram_rd_capture;

    localparam int IDDR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cancel;
    logic [4:0]  latency;
    logic [5:0]  burst_len;
    logic [7:0]  q0, q1;
    logic        rwds_q0, rwds_q1;
    logic [15:0] rdata;
    logic        rdata_valid, busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_done   = 0;
    logic [15:0] sb[$];

    bit pat0 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit pat1 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    psram_rd_capture dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel),
        .latency(latency), .burst_len(burst_len),
        .q0(q0), .q1(q1), .rwds_q0(rwds_q0), .rwds_q1(rwds_q1),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample #1 after the edge; strobed words are
    // popped from the scoreboard here.
    task automatic step();
        @(posedge clk);
        #1;
        if (rdata_valid) begin
            n_valid++;
            if (sb.size() == 0) check_b("sb_underflow", 1'b1, 1'b0);
            else check_w("rdata", 32'(rdata), 32'(sb.pop_front()));
        end
        if (done) n_done++;
    endtask

    task automatic drive_rwds_default();
`ifdef PSRAM_RD_CAPTURE_RWDS_EN
        rwds_q0 = 1'b1; rwds_q1 = 1'b0;
`else
        rwds_q0 = 1'($urandom); rwds_q1 = 1'($urandom);
`endif
    endtask

    // One transaction started in the current cycle (T). cx>0 pulses cancel
    // in cycle T+cx; poke re-pulses start in WAIT and on the done cycle.
    task automatic run(input int lat, input int bl, input int cx, input bit poke, input int tail);
        int f, endc, nv, v0, d0;
        logic [7:0] a, b;
        f    = lat + 1 + IDDR;
        endc = (cx > 0) ? cx : ((bl == 0) ? 1 : f + bl);
        nv = 0; v0 = n_valid; d0 = n_done;
        latency = 5'(lat); burst_len = 6'(bl); start = 1'b1;
        for (int c = 1; c <= endc + tail; c++) begin
            step();
            check_b("busy", busy, c <= endc);
            check_b("done", done, cx == 0 && c == endc);
            check_b("valid", rdata_valid, c >= f + 1 && c <= f + bl && (cx == 0 || c <= cx));
            start  = poke && (c == 2 || c == endc);
            cancel = (c == cx);
            if (c == 1) begin
                latency = 5'($urandom); burst_len = 6'($urandom);
            end
            a = 8'($urandom); b = 8'($urandom);
            q0 = a; q1 = b;
            drive_rwds_default();
            if (c >= f && c < f + bl && (cx == 0 || c < cx)) begin
                sb.push_back({a, b});
                nv++;
            end
        end
        start = 1'b0; cancel = 1'b0;
        check_w("n_valid", 32'(n_valid - v0), 32'(nv));
        check_w("n_done", 32'(n_done - d0), (cx == 0) ? 32'd1 : 32'd0);
        check_w("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int got, v0, d0, done_c;
        logic [7:0] a, b;
        logic qual;
        reset = 1'b1; start = 1'b0; cancel = 1'b0;
        latency = '0; burst_len = '0; q0 = '0; q1 = '0;
        rwds_q0 = 1'b0; rwds_q1 = 1'b0;
        #1;
        check_w("rst_rdata", 32'(rdata), 32'd0);
        check_b("rst_valid", rdata_valid, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_done", done, 1'b0);
        repeat (2) step();
        reset = 1'b0;
        step();

        run(3, 4, 0, 1'b0, 2);   // nominal burst
        run(0, 0, 0, 1'b0, 2);   // zero-length burst
        run(0, 8, 5, 1'b0, 1);   // cancel on 3rd capture cycle
        run(2, 3, 0, 1'b0, 2);   // start right after cancel
        run(3, 4, 0, 1'b1, 2);   // ignored starts while busy
        run(5, 1, 0, 1'b0, 2);   // single word
        run(31, 2, 0, 1'b0, 2);  // max latency
        run(0, 63, 0, 1'b0, 2);  // max burst

        // RWDS qualification: pattern 10,00,10,11,10 over the capture window
        got = 0; v0 = n_valid; d0 = n_done;
`ifdef PSRAM_RD_CAPTURE_RWDS_EN
        done_c = 3 + 5;
`else
        done_c = 3 + 3;
`endif
        latency = 5'd0; burst_len = 6'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            check_b("rwds_done", done, c == done_c);
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            q0 = a; q1 = b;
            if (c >= 3 && c <= 7) begin
                rwds_q0 = pat0[c-3]; rwds_q1 = pat1[c-3];
            end else begin
                rwds_q0 = 1'b0; rwds_q1 = 1'b0;
            end
`ifdef PSRAM_RD_CAPTURE_RWDS_EN
            qual = (c >= 3) && rwds_q0 && !rwds_q1 && got < 3;
`else
            qual = (c >= 3) && got < 3;
`endif
            if (qual) begin
                sb.push_back({a, b});
                got++;
            end
        end
        check_w("rwds_n_valid", 32'(n_valid - v0), 32'd3);
        check_w("rwds_n_done", 32'(n_done - d0), 32'd1);

        // Asynchronous reset in the middle of CAPTURE
        latency = 5'd1; burst_len = 6'd8; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom);
            q0 = a; q1 = b;
            drive_rwds_default();
            if (c >= 4 && c < 6) sb.push_back({a, b});
        end
        check_b("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_w("mid_rst_rdata", 32'(rdata), 32'd0);
        check_b("mid_rst_valid", rdata_valid, 1'b0);
        check_b("mid_rst_busy", busy, 1'b0);
        check_b("mid_rst_done", done, 1'b0);
        sb.delete();
        step();
        step();
        reset = 1'b0;
        step();
        run(1, 3, 0, 1'b0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_rd_capture.md
Name: psram_rd_capture

Overview:
- Read-data capture stage directly downstream of the PSRAM DQ/RWDS input DDR registers.
- Consumes the per-clock rising/falling byte pairs (q0/q1) those registers deliver with a fixed 2-cycle pipeline.
- Skips the PSRAM initial latency, assembles 16-bit words, counts the burst and hands words to the PSRAM controller as a valid-strobed stream with busy/done status.

Parameters:
- IDDR_LAT, 2, pipeline depth (clk cycles) of the upstream DDR input registers; added to the latency wait.
- LAT_W, 5, width of latency input.
- BL_W, 6, width of burst length input (max 63 words).

Ports:
- clk  input  1  system clock; same clock drives the upstream DDR registers.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a read capture. Ignored while busy.
- cancel  input  1  synchronous abort; returns to IDLE, no done.
- latency  input  LAT_W  clk cycles from start to first valid DQ at the pads; sampled on start.
- burst_len  input  BL_W  words to capture; sampled on start.
- q0  input  8  DQ byte sampled on rising edge (upstream Q0).
- q1  input  8  DQ byte sampled on falling edge (upstream Q1).
- rwds_q0  input  1  RWDS rising sample.
- rwds_q1  input  1  RWDS falling sample.
- rdata  output  16  captured word, {q0,q1} (rising byte = [15:8]).
- rdata_valid  output  1  one-cycle strobe per captured word.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset values (async, immediate): state=IDLE, rdata=16'h0000, rdata_valid=0, busy=0, done=0, counters 0.
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE: on start (cycle T), latch burst_len and wait_cnt = latency + IDDR_LAT, using a LAT_W+2-bit sum with no overflow.
  - burst_len==0: go to DONE.
  - else wait_cnt==0: go to CAPTURE.
  - else: go to WAIT.
- WAIT: wait_cnt decrements each cycle. When wait_cnt==1, go to CAPTURE. WAIT lasts exactly latency+IDDR_LAT cycles (T+1 .. T+latency+IDDR_LAT).
- CAPTURE: each qualifying cycle registers rdata<={q0,q1} and asserts rdata_valid next cycle, then decrements the remaining count.
  - When the last word is sampled, go to DONE.
  - First sample is taken in cycle T+1+latency+IDDR_LAT.
- DONE: one cycle. done=1, coincident with the last rdata_valid. For burst_len==0, done is at T+1 with no rdata_valid. Then go to IDLE.
- rdata holds its last value between strobes; it changes only when a word is captured.
- start while busy (including the DONE cycle): ignored. A new start is accepted from IDLE only, so back-to-back starts have at least 1 idle cycle.
- cancel (any non-IDLE state): next state IDLE.
  - No done; no further rdata_valid.
  - A word sampled in the same cycle as cancel is discarded.
  - cancel has priority over start, capture and completion.
  - cancel in IDLE has no effect.
- Reset mid-burst: immediate return to the reset state; pending words are lost.
- Arithmetic: the remaining counter is BL_W bits, loaded with burst_len and decremented to 0; no wrap is possible.

Optional Feature:
- Macro: PSRAM_RD_CAPTURE_RWDS_EN.
- Defined: in CAPTURE, a cycle qualifies only when rwds_q0==1 && rwds_q1==0 (RWDS toggling as data strobe). Non-qualifying cycles stall without a timeout; cancel is the escape.
- Not defined: every CAPTURE cycle qualifies; rwds_q0/rwds_q1 are ignored (ports remain, unused).

Decomposition:
- Shared package psram_pkg: state encodings (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_CAPTURE=2'd2, ST_DONE=2'd3), IDDR_LAT default constant, BL_W/LAT_W defaults.
- Single module; no sub-module warranted.
- The upstream IDDR instances stay in the PHY wrapper, not inside this block.

Test Plan:
- latency=3, burst_len=4, q0/q1 driven {A0,A1},{B0,B1},{C0,C1},{D0,D1} from cycle T+6 -> rdata_valid at T+7..T+10 with 16'hA0A1,16'hB0B1,16'hC0C1,16'hD0D1; done only at T+10; busy T+1..T+10.
- latency=0, burst_len=0 -> busy only at T+1, done at T+1, no rdata_valid.
- burst_len=8, cancel at 3rd CAPTURE cycle -> exactly 2 rdata_valid, no done, busy low next cycle; start 1 cycle later is accepted normally.
- start pulsed again during WAIT and on the done cycle -> ignored; single burst of burst_len words, single done.
- reset asserted mid-CAPTURE between clock edges -> outputs zero immediately; after release, a fresh start works.
- PSRAM_RD_CAPTURE_RWDS_EN defined, burst_len=3, RWDS pattern 10,00,10,11,10 -> 3 words from the qualifying cycles only, done with the third; undefined build -> 3 words on the first 3 cycles.
